if_fetch: RTL

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a req/ack instruction bus.
- Presents if_pc/if_inst to IF/ID and raises stallreq_from_if while no instruction is ready, so ctrl issues stall=6'b000011 and IF/ID inserts a bubble.
- Handles MIPS branch (delay-slot) redirects from ID and exception flush redirects from ctrl.

---
 rtl/if_fetch_pkg.sv | 19 +
 rtl/if_fetch.sv | 129 ++++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// Shared constants and fetch-state encoding for the instruction-fetch stage.
package if_fetch_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic        STOP       = 1'b1;
  localparam logic        NO_STOP    = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'b00,
    IF_FETCH   = 2'b01,
    IF_HOLD    = 2'b10,
    IF_DISCARD = 2'b11
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the req/ack instruction bus and
// feeds IF/ID, holding delay-slot branch targets and exception redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               stall,
  input  logic                     flush,
  input  logic [INST_ADDR_BUS-1:0] new_pc,
  input  logic                     branch_flag_i,
  input  logic [INST_ADDR_BUS-1:0] branch_target_address_i,
  output logic                     ibus_req_o,
  output logic [INST_ADDR_BUS-1:0] ibus_addr_o,
  input  logic                     ibus_ack_i,
  input  logic [INST_BUS-1:0]      ibus_rdata_i,
  output logic [INST_ADDR_BUS-1:0] if_pc,
  output logic [INST_BUS-1:0]      if_inst,
  output logic                     stallreq_from_if,
  output if_state_e                dbg_state
);

  if_state_e                state;
  logic [INST_ADDR_BUS-1:0] pc;
  logic [INST_ADDR_BUS-1:0] next_pc;
  logic [INST_ADDR_BUS-1:0] br_tgt;
  logic [INST_ADDR_BUS-1:0] disc_addr;
  logic [INST_BUS-1:0]      inst_buf;
  logic                     br_pend;
  logic                     advance;
  logic                     unused_stall;

  assign unused_stall = ^{stall[5:3], stall[1]};
  assign dbg_state    = state;

  // The PC moves only when the current instruction is handed to IF/ID.
  assign advance = !flush && (stall[0] == NO_STOP) &&
                   ((state == IF_FETCH && ibus_ack_i) || state == IF_HOLD);

  always_comb begin
    next_pc = pc + 32'd4;
    if (branch_flag_i)
      next_pc = branch_target_address_i;
    else if (br_pend)
      next_pc = br_tgt;
  end

  // Outputs depend on state, flush and the bus only, never on stall.
  always_comb begin
    ibus_req_o       = 1'b0;
    ibus_addr_o      = pc;
    if_pc            = ZERO_WORD;
    if_inst          = ZERO_WORD;
    stallreq_from_if = 1'b1;
    case (state)
      IF_FETCH: begin
        ibus_req_o = 1'b1;
        if (ibus_ack_i) begin
          stallreq_from_if = 1'b0;
          if (!flush) begin
            if_pc   = pc;
            if_inst = ibus_rdata_i;
          end
        end
      end
      IF_HOLD: begin
        stallreq_from_if = 1'b0;
        if (!flush) begin
          if_pc   = pc;
          if_inst = inst_buf;
        end
      end
      IF_DISCARD: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = disc_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state     <= IF_IDLE;
      pc        <= RESET_PC;
      br_pend   <= 1'b0;
      br_tgt    <= ZERO_WORD;
      inst_buf  <= ZERO_WORD;
      disc_addr <= ZERO_WORD;
    end else if (flush) begin
      pc      <= new_pc;
      br_pend <= 1'b0;
      case (state)
        IF_FETCH: begin
          // The outstanding access cannot be cancelled; drain it first.
          if (!ibus_ack_i) begin
            state     <= IF_DISCARD;
            disc_addr <= pc;
          end
        end
        IF_DISCARD: if (ibus_ack_i) state <= IF_FETCH;
        default:    state <= IF_FETCH;
      endcase
    end else begin
      case (state)
        IF_IDLE: state <= IF_FETCH;
        IF_FETCH: begin
          if (ibus_ack_i && stall[0] == STOP) begin
            inst_buf <= ibus_rdata_i;
            state    <= IF_HOLD;
          end
        end
        IF_HOLD:    if (stall[0] == NO_STOP) state <= IF_FETCH;
        IF_DISCARD: if (ibus_ack_i) state <= IF_FETCH;
        default:    state <= IF_IDLE;
      endcase
      if (advance) begin
        pc      <= next_pc;
        br_pend <= 1'b0;
      end else if (branch_flag_i && stall[2] == NO_STOP) begin
        // Branch leaves ID before its delay slot is fetched; remember the target.
        br_pend <= 1'b1;
        br_tgt  <= branch_target_address_i;
      end
    end
  end

endmodule
